alu_seq: RTL and testbench

- Parametrised successor to the 32-bit ALU. Width-generic operands, 2×Width result.
- Add is computed in one cycle; multiply and divide run as real multi-cycle iterative operations.
- Full valid/ready handshake on both input and output. Sits between the UART command parser (producer) and the UART response serialiser (consumer).

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_seq_if.sv | 23 ++
 rtl/alu_seq_core.sv | 67 ++++++
 rtl/alu_seq.sv | 107 ++++++++++
 tb/tb_alu_seq.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: command opcodes and control states.
package alu_pkg;

    typedef enum logic [1:0] {
        Nop      = 2'd0,
        Add      = 2'd1,
        Multiply = 2'd2,
        Divide   = 2'd3
    } opcode_e;

    typedef enum logic [1:0] {
        Idle = 2'd0,
        Busy = 2'd1,
        Done = 2'd2
    } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Command/response handshake bundle between the UART parser, the ALU and the response serialiser.
interface alu_seq_if #(
    parameter int Width = 32
);
    logic               valid_i;
    logic [1:0]         opcode_i;
    logic [Width-1:0]   operand_a_i;
    logic [Width-1:0]   operand_b_i;
    logic               ready_o;
    logic               ready_i;
    logic [2*Width-1:0] result_o;
    logic               valid_o;

    modport master (
        output valid_i, opcode_i, operand_a_i, operand_b_i, ready_i,
        input  ready_o, result_o, valid_o
    );

    modport slave (
        input  valid_i, opcode_i, operand_a_i, operand_b_i, ready_i,
        output ready_o, result_o, valid_o
    );
endinterface

// File: rtl/alu_seq_core.sv
// Iterative datapath shared by shift-add multiply and restoring divide.
// hi/lo hold partial product:multiplier or remainder:quotient depending on the operation.
module alu_seq_core #(
    parameter int Width  = 32,
    parameter int CountW = $clog2(Width) + 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               op_div_i,
    input  logic [Width-1:0]   operand_a_i,
    input  logic [Width-1:0]   operand_b_i,
    output logic               last_step_o,
    output logic [2*Width-1:0] result_o
);

    logic              isDiv_q;
    logic [Width-1:0]  operand_q;
    logic [Width-1:0]  hi_q, hi_d;
    logic [Width-1:0]  lo_q, lo_d;
    logic [CountW-1:0] count_q;

    logic [Width:0]    mulSum;
    logic [Width:0]    divShift;
    logic [Width:0]    divTrial;
    logic              divFits;

    // One iteration: multiply adds then shifts right, divide shifts left then trial-subtracts.
    always_comb begin
        mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, operand_q} : '0);
        divShift = {hi_q, lo_q[Width-1]};
        divFits  = (divShift >= {1'b0, operand_q});
        divTrial = divShift - {1'b0, operand_q};
        if (isDiv_q) begin
            hi_d = divFits ? divTrial[Width-1:0] : divShift[Width-1:0];
            lo_d = {lo_q[Width-2:0], divFits};
        end else begin
            hi_d = mulSum[Width:1];
            lo_d = {mulSum[0], lo_q[Width-1:1]};
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            isDiv_q   <= 1'b0;
            operand_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            count_q   <= '0;
        end else if (start_i) begin
            isDiv_q   <= op_div_i;
            operand_q <= op_div_i ? operand_b_i : operand_a_i;
            hi_q      <= '0;
            lo_q      <= op_div_i ? operand_a_i : operand_b_i;
            count_q   <= CountW'(Width);
        end else if (count_q != '0) begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            count_q   <= count_q - CountW'(1);
        end
    end

    // The top captures the final iteration's next value directly, saving a cycle.
    assign last_step_o = (count_q == CountW'(1));
    assign result_o    = {hi_d, lo_d};

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU top: handshake FSM, single-cycle add path and result register.
// Multiply and divide are delegated to the iterative core.
module alu_seq
    import alu_pkg::*;
#(
    parameter int Width  = 32,
    parameter int CountW = $clog2(Width) + 1
) (
    input  logic      clk_i,
    input  logic      reset_i,
    alu_seq_if.slave  bus
);

    state_e             state_q, state_d;
    logic [2*Width-1:0] result_q, result_d;

    opcode_e            opcode;
    logic [Width:0]     addSum;
    logic               divByZero;
    logic               coreStart;
    logic               coreDiv;
    logic               coreLast;
    logic [2*Width-1:0] coreResult;

    assign opcode    = opcode_e'(bus.opcode_i);
    assign addSum    = {1'b0, bus.operand_a_i} + {1'b0, bus.operand_b_i};
    assign divByZero = (bus.operand_b_i == '0);
    assign coreDiv   = (opcode == Divide);

    alu_seq_core #(
        .Width  (Width),
        .CountW (CountW)
    ) u_core (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .start_i     (coreStart),
        .op_div_i    (coreDiv),
        .operand_a_i (bus.operand_a_i),
        .operand_b_i (bus.operand_b_i),
        .last_step_o (coreLast),
        .result_o    (coreResult)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= Idle;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    // Done never re-accepts in the same cycle it hands off, so commands are at most one per two cycles.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        coreStart = 1'b0;
        case (state_q)
            Idle: begin
                if (bus.valid_i) begin
                    case (opcode)
                        Nop: begin
                            result_d = '0;
                            state_d  = Done;
                        end
                        Add: begin
                            result_d = {{(Width-1){1'b0}}, addSum};
                            state_d  = Done;
                        end
                        Multiply: begin
                            coreStart = 1'b1;
                            state_d   = Busy;
                        end
                        Divide: begin
                            if (divByZero) begin
                                result_d = {bus.operand_a_i, {Width{1'b1}}};
                                state_d  = Done;
                            end else begin
                                coreStart = 1'b1;
                                state_d   = Busy;
                            end
                        end
                        default: state_d = Idle;
                    endcase
                end
            end
            Busy: begin
                if (coreLast) begin
                    result_d = coreResult;
                    state_d  = Done;
                end
            end
            Done: begin
                if (bus.ready_i) begin
                    state_d = Idle;
                end
            end
            default: state_d = Idle;
        endcase
    end

    assign bus.ready_o  = (state_q == Idle);
    assign bus.valid_o  = (state_q == Done);
    assign bus.result_o = result_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at Width = 32.
module tb_alu_seq;
    import alu_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    alu_seq_if #(.Width(32)) bus ();

    alu_seq #(.Width(32)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one command across a single accept edge; returns at the negedge after that edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.valid_i     = 1'b1;
        bus.opcode_i    = op;
        bus.operand_a_i = a;
        bus.operand_b_i = b;
        @(negedge clk);
        bus.valid_i     = 1'b0;
    endtask

    // lat counts cycles from the accept cycle; busyBad flags ready_o seen high before valid_o.
    task automatic waitValid(output int lat, output int busyBad);
        lat     = 1;
        busyBad = 0;
        while (bus.valid_o !== 1'b1 && lat < 200) begin
            if (bus.ready_o !== 1'b0) busyBad++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst             = 1'b1;
        bus.valid_i     = 1'b0;
        bus.opcode_i    = 2'd0;
        bus.operand_a_i = '0;
        bus.operand_b_i = '0;
        bus.ready_i     = 1'b1;
        #12;
        checks++;
        if (bus.ready_o !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 1", bus.ready_o); end
        checks++;
        if (bus.valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.valid_o); end
        checks++;
        if (bus.result_o !== 64'h0) begin failures++; $display("[TB] FAIL reset_result: got %h expected 0", bus.result_o); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        int lat, busyBad;
        bus.ready_i = 1'b1;
        applyStimulus(Add, 32'hFFFF_FFFF, 32'h0000_0001);
        waitValid(lat, busyBad);
        checks++;
        if (lat !== 1) begin failures++; $display("[TB] FAIL add_latency: got %0d expected 1", lat); end
        checks++;
        if (bus.result_o !== 64'h0000_0001_0000_0000) begin failures++; $display("[TB] FAIL add_result: got %h expected 0000000100000000", bus.result_o); end
        @(negedge clk);
        checks++;
        if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
            failures++; $display("[TB] FAIL add_return_idle: got ready=%b valid=%b expected ready=1 valid=0", bus.ready_o, bus.valid_o);
        end
    endtask

    task automatic test_multiply();
        int lat, busyBad;
        bus.ready_i = 1'b1;
        applyStimulus(Multiply, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitValid(lat, busyBad);
        checks++;
        if (lat !== 33) begin failures++; $display("[TB] FAIL mul_latency: got %0d expected 33", lat); end
        checks++;
        if (busyBad !== 0) begin failures++; $display("[TB] FAIL mul_busy_ready: got %0d cycles with ready_o high expected 0", busyBad); end
        checks++;
        if (bus.result_o !== 64'hFFFF_FFFE_0000_0001) begin failures++; $display("[TB] FAIL mul_result: got %h expected FFFFFFFE00000001", bus.result_o); end
        @(negedge clk);
    endtask

    task automatic test_divide();
        int lat, busyBad;
        bus.ready_i = 1'b1;
        applyStimulus(Divide, 32'd100, 32'd7);
        waitValid(lat, busyBad);
        checks++;
        if (lat !== 33) begin failures++; $display("[TB] FAIL div_latency: got %0d expected 33", lat); end
        // 100 = 7 * 14 + 2
        checks++;
        if (bus.result_o !== 64'h0000_0002_0000_000E) begin failures++; $display("[TB] FAIL div_result: got %h expected 000000020000000E", bus.result_o); end
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        int lat, busyBad;
        bus.ready_i = 1'b1;
        applyStimulus(Divide, 32'h0000_1234, 32'h0);
        waitValid(lat, busyBad);
        checks++;
        if (lat !== 1) begin failures++; $display("[TB] FAIL divzero_latency: got %0d expected 1", lat); end
        checks++;
        if (bus.result_o !== 64'h0000_1234_FFFF_FFFF) begin failures++; $display("[TB] FAIL divzero_result: got %h expected 00001234FFFFFFFF", bus.result_o); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int lat, busyBad, holdBad;
        bus.ready_i = 1'b0;
        applyStimulus(Multiply, 32'd3, 32'd5);
        waitValid(lat, busyBad);
        checks++;
        if (lat !== 33 || bus.result_o !== 64'd15) begin
            failures++; $display("[TB] FAIL bp_first_result: got lat=%0d result=%h expected lat=33 result=f", lat, bus.result_o);
        end
        holdBad = 0;
        for (int i = 0; i < 10; i++) begin
            bus.valid_i     = 1'b1;
            bus.opcode_i    = Add;
            bus.operand_a_i = 32'd1;
            bus.operand_b_i = 32'd1;
            @(negedge clk);
            if (bus.valid_o !== 1'b1 || bus.ready_o !== 1'b0 || bus.result_o !== 64'd15) holdBad++;
        end
        checks++;
        if (holdBad !== 0) begin failures++; $display("[TB] FAIL bp_hold: got %0d bad stall cycles expected 0", holdBad); end
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
            failures++; $display("[TB] FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1", bus.valid_o, bus.ready_o);
        end
    endtask

    task automatic test_reset_mid_divide();
        int lat, busyBad;
        bus.ready_i = 1'b1;
        applyStimulus(Divide, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1 || bus.result_o !== 64'h0) begin
            failures++; $display("[TB] FAIL midreset_outputs: got valid=%b ready=%b result=%h expected 0 1 0", bus.valid_o, bus.ready_o, bus.result_o);
        end
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(Add, 32'd2, 32'd3);
        waitValid(lat, busyBad);
        checks++;
        if (lat !== 1 || bus.result_o !== 64'd5) begin
            failures++; $display("[TB] FAIL midreset_add: got lat=%0d result=%h expected lat=1 result=5", lat, bus.result_o);
        end
        @(negedge clk);
    endtask

    task automatic checkOutput();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_add();
        test_multiply();
        test_divide();
        test_div_zero();
        test_backpressure();
        test_reset_mid_divide();
        checkOutput();
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
